muldiv_seq: RTL

Parametrised sequential unsigned multiplier/divider for the calculator datapath. Shift-add multiply and restoring divide share one accumulator/shift register and one WIDTH-bit adder/subtractor. A start/busy/done handshake drives it from the calculator control FSM. Results are held until the next accepted start.

---
 rtl/muldiv_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Sequential shift-add multiplier / restoring divider sharing one accumulator and adder.
// Optional `MULDIV_SIGNED_EN adds signed_op for two's-complement operands (sign fixed at DONE load).
module muldiv_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
`ifdef MULDIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rsh, lhs, rhs;
    logic [WIDTH+1:0] sum;
    logic             no_borrow;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] fin_hi, fin_lo;

`ifdef MULDIV_SIGNED_EN
    logic             sa, sb;
    logic             negp_q, negp_d, negr_q, negr_d;
    logic [2*WIDTH-1:0] prod_mag;

    assign sa    = signed_op & a[WIDTH-1];
    assign sb    = signed_op & b[WIDTH-1];
    assign a_mag = sa ? (~a + 1'b1) : a;
    assign b_mag = sb ? (~b + 1'b1) : b;
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // One adder: multiply adds the gated operand, divide adds ~b + 1 so the carry-out is "no borrow".
    assign rsh       = {hi_q, lo_q[WIDTH-1]};
    assign lhs       = op_q ? rsh : {1'b0, hi_q};
    assign rhs       = op_q ? ~{1'b0, opnd_q} : (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign sum       = {1'b0, lhs} + {1'b0, rhs} + {{(WIDTH + 1){1'b0}}, op_q};
    assign no_borrow = sum[WIDTH+1];

    always_comb begin
        if (op_q) begin
            step_hi = no_borrow ? sum[WIDTH-1:0] : rsh[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], no_borrow};
        end else begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

`ifdef MULDIV_SIGNED_EN
    assign prod_mag = {step_hi, step_lo};
    always_comb begin
        fin_hi = step_hi;
        fin_lo = step_lo;
        if (op_q) begin
            if (negp_q) fin_lo = ~step_lo + 1'b1;
            if (negr_q) fin_hi = ~step_hi + 1'b1;
        end else if (negp_q) begin
            {fin_hi, fin_lo} = ~prod_mag + 1'b1;
        end
    end
`else
    assign fin_hi = step_hi;
    assign fin_lo = step_lo;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dbz_d    = dbz_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
`ifdef MULDIV_SIGNED_EN
        negp_d   = negp_q;
        negr_d   = negr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    dbz_d = 1'b0;
                    cnt_d = '0;
`ifdef MULDIV_SIGNED_EN
                    negp_d = sa ^ sb;
                    negr_d = sa;
`endif
                    if (op && (b == '0)) begin
                        state_d  = S_DONE;
                        res_lo_d = '1;
                        res_hi_d = a;
                        dbz_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        opnd_d  = op ? b_mag : a_mag;
                        hi_d    = '0;
                        lo_d    = op ? a_mag : b_mag;
                    end
                end
            end
            S_RUN: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    res_hi_d = fin_hi;
                    res_lo_d = fin_lo;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            dbz_q    <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
`ifdef MULDIV_SIGNED_EN
            negp_q   <= 1'b0;
            negr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            dbz_q    <= dbz_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
`ifdef MULDIV_SIGNED_EN
            negp_q   <= negp_d;
            negr_q   <= negr_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign result_hi   = res_hi_q;
    assign result_lo   = res_lo_q;
    assign div_by_zero = dbz_q;

endmodule
